// File: rtl/sram_ctrl.sv
// sram_ctrl
// -----------------------------------------------------------------------------
// Handles data-memory requests from the LSU. Each 32-bit load or store becomes
// zero, one or two 16-bit accesses on an external 256Kx16 asynchronous SRAM.
// The LO halfword is accessed first, then the HI halfword. While an access is
// in progress, o_stall keeps the core's PC on hold.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst_n     synchronous active-low reset
//   i_req       request valid; only looked at while idle
//   i_wren      1 = store, 0 = load
//   i_addr      byte address; bits [1:0] are ignored (word aligned)
//   i_bmask     store byte enables; bit n selects byte n of i_wdata
//   i_wdata     store data
//   o_rdata     load data; valid in the o_ack cycle and held until the next load
//   o_ack       one-cycle completion pulse
//   o_stall     core must hold PC/instruction (combinational)
//   SRAM_ADDR   halfword address to the SRAM
//   SRAM_D      write data to the SRAM pins
//   SRAM_Q      read data from the SRAM pins
//   SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N   active-low strobes
// -----------------------------------------------------------------------------
module sram_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_wren,
  input  logic [18:0] i_addr,
  input  logic [3:0]  i_bmask,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_stall,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_D,
  input  logic [15:0] SRAM_Q,
  output logic        SRAM_CE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic           wren_r, wren_s;
  logic [16:0]    addr_r, addr_s;
  logic [3:0]     mask_r, mask_s;
  logic [31:0]    wdata_r, wdata_s;
  logic           last_s;

  logic [17:0]    pin_addr_s;
  logic [15:0]    pin_d_s;
  logic           pin_ce_n_s;
  logic           pin_we_n_s;
  logic           pin_oe_n_s;
  logic           pin_lb_n_s;
  logic           pin_ub_n_s;

  // The byte offset is architecturally ignored; folding it here marks it as intentionally unused.
  logic           unused_addr_s;
  assign unused_addr_s = ^i_addr[1:0];

  assign last_s = (cnt_r == CNT_LAST);

  // The core is stalled from the accept cycle through the last phase cycle. DONE
  // releases the stall so that the core advances at the edge that ends DONE.
  assign o_stall = ((state_r == ST_IDLE) && i_req) || (state_r == ST_LO) || (state_r == ST_HI);

  // Next-state logic: request latch, phase sequencing and the per-phase wait counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    wren_s  = wren_r;
    addr_s  = addr_r;
    mask_s  = mask_r;
    wdata_s = wdata_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (i_req) begin
          wren_s  = i_wren;
          addr_s  = i_addr[18:2];
          mask_s  = i_bmask;
          wdata_s = i_wdata;
          // Loads always read both halves. Stores skip any halfword whose byte enables are all clear.
          if (!i_wren || (|i_bmask[1:0])) begin
            state_s = ST_LO;
          end else if (|i_bmask[3:2]) begin
            state_s = ST_HI;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LO: begin
        if (last_s) begin
          cnt_s = CNT_ZERO;
          if (!wren_r || (|mask_r[3:2])) begin
            state_s = ST_HI;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HI: begin
        if (last_s) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Pin values are decoded from the next state so that the registered pins line up with the phase.
  always_comb begin
    pin_addr_s = 18'h00000;
    pin_d_s    = 16'h0000;
    pin_ce_n_s = 1'b1;
    pin_we_n_s = 1'b1;
    pin_oe_n_s = 1'b1;
    pin_lb_n_s = 1'b1;
    pin_ub_n_s = 1'b1;
    case (state_s)
      ST_LO: begin
        pin_addr_s = {addr_s, 1'b0};
        pin_d_s    = wdata_s[15:0];
        pin_ce_n_s = 1'b0;
        pin_we_n_s = ~wren_s;
        pin_oe_n_s = wren_s;
        pin_lb_n_s = wren_s ? ~mask_s[0] : 1'b0;
        pin_ub_n_s = wren_s ? ~mask_s[1] : 1'b0;
      end
      ST_HI: begin
        pin_addr_s = {addr_s, 1'b1};
        pin_d_s    = wdata_s[31:16];
        pin_ce_n_s = 1'b0;
        pin_we_n_s = ~wren_s;
        pin_oe_n_s = wren_s;
        pin_lb_n_s = wren_s ? ~mask_s[2] : 1'b0;
        pin_ub_n_s = wren_s ? ~mask_s[3] : 1'b0;
      end
      default: begin
        pin_addr_s = 18'h00000;
        pin_d_s    = 16'h0000;
        pin_ce_n_s = 1'b1;
        pin_we_n_s = 1'b1;
        pin_oe_n_s = 1'b1;
        pin_lb_n_s = 1'b1;
        pin_ub_n_s = 1'b1;
      end
    endcase
  end

  // State, latched request, registered pins, ack and load-data capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      wren_r    <= 1'b0;
      addr_r    <= 17'h00000;
      mask_r    <= 4'h0;
      wdata_r   <= 32'h00000000;
      o_rdata   <= 32'h00000000;
      o_ack     <= 1'b0;
      SRAM_ADDR <= 18'h00000;
      SRAM_D    <= 16'h0000;
      SRAM_CE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      wren_r    <= wren_s;
      addr_r    <= addr_s;
      mask_r    <= mask_s;
      wdata_r   <= wdata_s;
      o_ack     <= (state_s == ST_DONE);
      SRAM_ADDR <= pin_addr_s;
      SRAM_D    <= pin_d_s;
      SRAM_CE_N <= pin_ce_n_s;
      SRAM_WE_N <= pin_we_n_s;
      SRAM_OE_N <= pin_oe_n_s;
      SRAM_LB_N <= pin_lb_n_s;
      SRAM_UB_N <= pin_ub_n_s;
      // Sample read data on the final cycle of a load phase, after the SRAM has had the full wait to settle.
      if (!wren_r && last_s && (state_r == ST_LO)) begin
        o_rdata[15:0] <= SRAM_Q;
      end
      if (!wren_r && last_s && (state_r == ST_HI)) begin
        o_rdata[31:16] <= SRAM_Q;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req1, req3;
  logic        wren;
  logic [18:0] addr;
  logic [3:0]  bmask;
  logic [31:0] wdata;

  logic [31:0] rdata1, rdata3;
  logic        ack1, ack3, stall1, stall3;
  logic [17:0] sa1, sa3;
  logic [15:0] sd1, sd3, sq1, sq3;
  logic        ce1, we1, oe1, lb1, ub1;
  logic        ce3, we3, oe3, lb3, ub3;

  logic [15:0] mem1 [0:262143];
  logic [15:0] mem3 [0:262143];

  int total = 0;
  int bad   = 0;

  bit sel = 1'b0;
  logic [31:0] m_rdata;
  logic        m_ack, m_stall, m_ce, m_we, m_oe, m_lb, m_ub;
  logic [17:0] m_sa;
  logic [15:0] m_sd;

  logic [17:0] snap_addr  [0:31];
  logic [15:0] snap_d     [0:31];
  logic        snap_ce    [0:31];
  logic        snap_we    [0:31];
  logic        snap_oe    [0:31];
  logic        snap_lb    [0:31];
  logic        snap_ub    [0:31];
  logic        snap_stall [0:31];
  logic        snap_ack   [0:31];
  logic [31:0] got_rd;

  logic [31:0] ref1 [int];
  logic [31:0] ref3 [int];
  logic [31:0] exp_rd1 = 32'h0;
  logic [31:0] exp_rd3 = 32'h0;

  sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_wren(wren), .i_addr(addr),
    .i_bmask(bmask), .i_wdata(wdata), .o_rdata(rdata1), .o_ack(ack1), .o_stall(stall1),
    .SRAM_ADDR(sa1), .SRAM_D(sd1), .SRAM_Q(sq1), .SRAM_CE_N(ce1), .SRAM_WE_N(we1),
    .SRAM_OE_N(oe1), .SRAM_LB_N(lb1), .SRAM_UB_N(ub1)
  );

  sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req3), .i_wren(wren), .i_addr(addr),
    .i_bmask(bmask), .i_wdata(wdata), .o_rdata(rdata3), .o_ack(ack3), .o_stall(stall3),
    .SRAM_ADDR(sa3), .SRAM_D(sd3), .SRAM_Q(sq3), .SRAM_CE_N(ce3), .SRAM_WE_N(we3),
    .SRAM_OE_N(oe3), .SRAM_LB_N(lb3), .SRAM_UB_N(ub3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural async SRAM models: combinational read, byte-lane write at each clock while enabled
  assign sq1 = (!ce1 && !oe1) ? mem1[sa1] : 16'h0000;
  assign sq3 = (!ce3 && !oe3) ? mem3[sa3] : 16'h0000;
  always @(posedge clk) begin
    if (!ce1 && !we1) begin
      if (!lb1) mem1[sa1][7:0]  <= sd1[7:0];
      if (!ub1) mem1[sa1][15:8] <= sd1[15:8];
    end
    if (!ce3 && !we3) begin
      if (!lb3) mem3[sa3][7:0]  <= sd3[7:0];
      if (!ub3) mem3[sa3][15:8] <= sd3[15:8];
    end
  end

  assign m_rdata = sel ? rdata3 : rdata1;
  assign m_ack   = sel ? ack3   : ack1;
  assign m_stall = sel ? stall3 : stall1;
  assign m_sa    = sel ? sa3    : sa1;
  assign m_sd    = sel ? sd3    : sd1;
  assign m_ce    = sel ? ce3    : ce1;
  assign m_we    = sel ? we3    : we1;
  assign m_oe    = sel ? oe3    : oe1;
  assign m_lb    = sel ? lb3    : lb1;
  assign m_ub    = sel ? ub3    : ub1;

  // Reference word store: byte-granular merge into a word-indexed memory
  task automatic ref_store(input bit s, input int widx, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] w;
    w = 32'h0;
    if (s) begin
      if (ref3.exists(widx)) w = ref3[widx];
    end else begin
      if (ref1.exists(widx)) w = ref1[widx];
    end
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    if (s) ref3[widx] = w; else ref1[widx] = w;
  endtask

  function automatic logic [31:0] ref_load(input bit s, input int widx);
    if (s) return ref3.exists(widx) ? ref3[widx] : 32'h0;
    return ref1.exists(widx) ? ref1[widx] : 32'h0;
  endfunction

  // One transaction, started at a negedge; snapshots pins per cycle (index = cycles after accept)
  task automatic txn(input bit s, input bit w, input logic [18:0] a, input logic [3:0] m,
                     input logic [31:0] d, input bit hold, output int lat);
    sel = s; wren = w; addr = a; bmask = m; wdata = d;
    if (s) req3 = 1'b1; else req1 = 1'b1;
    #1;
    snap_stall[0] = m_stall;
    @(posedge clk);
    #1;
    if (!hold) begin req1 = 1'b0; req3 = 1'b0; end
    lat = -1;
    for (int c = 1; c < 24 && lat < 0; c++) begin
      @(negedge clk);
      snap_addr[c] = m_sa; snap_d[c] = m_sd; snap_ce[c] = m_ce; snap_we[c] = m_we;
      snap_oe[c] = m_oe; snap_lb[c] = m_lb; snap_ub[c] = m_ub; snap_stall[c] = m_stall;
      snap_ack[c] = m_ack;
      if (m_ack) begin
        lat = c; got_rd = m_rdata; req1 = 1'b0; req3 = 1'b0;
      end
    end
    req1 = 1'b0; req3 = 1'b0;
    @(negedge clk);
    if (lat > 0) begin
      snap_ce[lat+1] = m_ce; snap_ack[lat+1] = m_ack; snap_stall[lat+1] = m_stall;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req1 = 1'b0; req3 = 1'b0; wren = 1'b0; addr = 19'h0; bmask = 4'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", ack1); end
    total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata1); end
    total++; if (sa1 !== 18'h0 || sd1 !== 16'h0) begin bad++; $display("FAIL rst_addr_d got=%h/%h exp=0/0", sa1, sd1); end
    total++; if ({ce1, we1, oe1, lb1, ub1, ce3, we3, oe3, lb3, ub3} !== 10'h3FF) begin bad++;
      $display("FAIL rst_strobes got=%b exp=all ones", {ce1, we1, oe1, lb1, ub1, ce3, we3, oe3, lb3, ub3}); end
    total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall1); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_basic();
    int lat;
    txn(1'b0, 1'b1, 19'h00010, 4'hF, 32'hDEADBEEF, 1'b0, lat);
    ref_store(1'b0, 4, 4'hF, 32'hDEADBEEF);
    total++; if (lat !== 3) begin bad++; $display("FAIL t1_lat got=%0d exp=3", lat); end
    total++; if (snap_stall[0] !== 1'b1) begin bad++; $display("FAIL t1_stall_T got=%b exp=1", snap_stall[0]); end
    total++; if (snap_addr[1] !== 18'h8 || snap_d[1] !== 16'hBEEF) begin bad++;
      $display("FAIL t1_lo got=%h/%h exp=00008/beef", snap_addr[1], snap_d[1]); end
    total++; if ({snap_ce[1], snap_we[1], snap_oe[1], snap_lb[1], snap_ub[1]} !== 5'b00100) begin bad++;
      $display("FAIL t1_lo_strobes got=%b exp=00100", {snap_ce[1], snap_we[1], snap_oe[1], snap_lb[1], snap_ub[1]}); end
    total++; if (snap_addr[2] !== 18'h9 || snap_d[2] !== 16'hDEAD) begin bad++;
      $display("FAIL t1_hi got=%h/%h exp=00009/dead", snap_addr[2], snap_d[2]); end
    total++; if (lat == 3 && snap_stall[3] !== 1'b0) begin bad++; $display("FAIL t1_stall_ack got=%b exp=0", snap_stall[3]); end
    total++; if (got_rd !== exp_rd1) begin bad++; $display("FAIL t1_rdata_hold got=%h exp=%h", got_rd, exp_rd1); end
  endtask

  task automatic test_load_basic();
    int lat;
    txn(1'b0, 1'b0, 19'h00010, 4'($urandom_range(0, 15)), 32'($urandom), 1'b0, lat);
    exp_rd1 = ref_load(1'b0, 4);
    total++; if (lat !== 3) begin bad++; $display("FAIL t2_lat got=%0d exp=3", lat); end
    total++; if ({snap_oe[1], snap_we[1], snap_oe[2], snap_we[2]} !== 4'b0101) begin bad++;
      $display("FAIL t2_strobes got=%b exp=0101", {snap_oe[1], snap_we[1], snap_oe[2], snap_we[2]}); end
    total++; if (got_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL t2_rdata got=%h exp=deadbeef", got_rd); end
  endtask

  task automatic test_partial_store();
    int lat;
    txn(1'b0, 1'b1, 19'h00010, 4'b0100, 32'h00AB0000, 1'b0, lat);
    ref_store(1'b0, 4, 4'b0100, 32'h00AB0000);
    total++; if (lat !== 2) begin bad++; $display("FAIL t3_lat got=%0d exp=2", lat); end
    total++; if (snap_addr[1] !== 18'h9 || snap_d[1] !== 16'h00AB || snap_lb[1] !== 1'b0 || snap_ub[1] !== 1'b1) begin bad++;
      $display("FAIL t3_hi got=%h/%h lb=%b ub=%b exp=00009/00ab lb=0 ub=1", snap_addr[1], snap_d[1], snap_lb[1], snap_ub[1]); end
    total++; if (got_rd !== exp_rd1) begin bad++; $display("FAIL t3_rdata_hold got=%h exp=%h", got_rd, exp_rd1); end
    txn(1'b0, 1'b0, 19'h00010, 4'h0, 32'h0, 1'b0, lat);
    exp_rd1 = ref_load(1'b0, 4);
    total++; if (got_rd !== 32'hDEABBEEF) begin bad++; $display("FAIL t3_reload got=%h exp=deabbeef", got_rd); end
  endtask

  task automatic test_empty_store();
    int lat;
    txn(1'b0, 1'b1, 19'h00020, 4'h0, 32'h12345678, 1'b0, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL t4_lat got=%0d exp=1", lat); end
    total++; if (snap_ce[1] !== 1'b1 || snap_stall[0] !== 1'b1 || snap_stall[1] !== 1'b0) begin bad++;
      $display("FAIL t4_ce_stall got=ce%b st%b%b exp=ce1 st10", snap_ce[1], snap_stall[0], snap_stall[1]); end
  endtask

  task automatic test_boundary();
    int lat;
    logic [31:0] d;
    d = 32'($urandom);
    txn(1'b0, 1'b1, 19'h7FFFC, 4'hF, d, 1'b0, lat);
    ref_store(1'b0, 32'h1FFFF, 4'hF, d);
    total++; if (snap_addr[1] !== 18'h3FFFE || snap_addr[2] !== 18'h3FFFF) begin bad++;
      $display("FAIL bnd_addr got=%h/%h exp=3fffe/3ffff", snap_addr[1], snap_addr[2]); end
    txn(1'b0, 1'b0, 19'h7FFFF, 4'h0, 32'h0, 1'b0, lat);
    exp_rd1 = ref_load(1'b0, 32'h1FFFF);
    total++; if (got_rd !== d) begin bad++; $display("FAIL bnd_load got=%h exp=%h", got_rd, d); end
  endtask

  task automatic test_wait3();
    int lat, nce;
    txn(1'b1, 1'b1, 19'h00010, 4'hF, 32'hDEADBEEF, 1'b0, lat);
    ref_store(1'b1, 4, 4'hF, 32'hDEADBEEF);
    total++; if (lat !== 7) begin bad++; $display("FAIL w3_store_lat got=%0d exp=7", lat); end
    txn(1'b1, 1'b0, 19'h00010, 4'h0, 32'h0, 1'b1, lat);
    exp_rd3 = ref_load(1'b1, 4);
    total++; if (lat !== 7) begin bad++; $display("FAIL w3_load_lat got=%0d exp=7", lat); end
    if (lat == 7) begin
      nce = 0;
      for (int c = 1; c <= 7; c++) if (snap_ce[c] === 1'b0) nce++;
      total++; if (nce !== 6) begin bad++; $display("FAIL w3_phase_cycles got=%0d exp=6", nce); end
      total++; if (snap_addr[1] !== 18'h8 || snap_addr[3] !== 18'h8 || snap_addr[4] !== 18'h9 || snap_addr[6] !== 18'h9) begin bad++;
        $display("FAIL w3_addr got=%h %h %h %h exp=8 8 9 9", snap_addr[1], snap_addr[3], snap_addr[4], snap_addr[6]); end
      total++; if ({snap_stall[0], snap_stall[1], snap_stall[6], snap_stall[7]} !== 4'b1110) begin bad++;
        $display("FAIL w3_stall got=%b exp=1110", {snap_stall[0], snap_stall[1], snap_stall[6], snap_stall[7]}); end
      total++; if (snap_ce[8] !== 1'b1 || snap_ack[8] !== 1'b0) begin bad++;
        $display("FAIL w3_single_access got=ce%b ack%b exp=ce1 ack0", snap_ce[8], snap_ack[8]); end
    end
    total++; if (got_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL w3_rdata got=%h exp=deadbeef", got_rd); end
  endtask

  task automatic test_random();
    int lat, pool [9], nph, elat, widx;
    bit w;
    logic [3:0] m;
    logic [31:0] d;
    logic [17:0] fa;
    for (int i = 0; i < 8; i++) pool[i] = 4 + i;
    pool[8] = 32'h1FFFF;
    for (int i = 0; i < 9; i++) begin
      d = 32'($urandom);
      txn(1'b0, 1'b1, {pool[i][16:0], 2'b00}, 4'hF, d, 1'b0, lat);
      ref_store(1'b0, pool[i], 4'hF, d);
    end
    for (int n = 0; n < 120; n++) begin
      widx = pool[$urandom_range(0, 8)];
      w = 1'($urandom_range(0, 1));
      m = 4'($urandom_range(0, 15));
      d = 32'($urandom);
      nph = w ? (((|m[1:0]) ? 1 : 0) + ((|m[3:2]) ? 1 : 0)) : 2;
      elat = 1 + nph;
      fa = {widx[16:0], (!w || (|m[1:0])) ? 1'b0 : 1'b1};
      txn(1'b0, w, {widx[16:0], 2'($urandom_range(0, 3))}, m, d, 1'b0, lat);
      total++; if (lat !== elat) begin bad++; $display("FAIL rnd_lat n=%0d got=%0d exp=%0d", n, lat, elat); end
      if (nph > 0) begin
        total++; if (snap_addr[1] !== fa) begin bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, snap_addr[1], fa); end
      end
      if (w) begin
        ref_store(1'b0, widx, m, d);
      end else begin
        exp_rd1 = ref_load(1'b0, widx);
      end
      total++; if (got_rd !== exp_rd1) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, got_rd, exp_rd1); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, nack;
    sel = 1'b0; wren = 1'b1; addr = 19'h00010; bmask = 4'hF; wdata = 32'h12345678; req1 = 1'b1;
    @(posedge clk);
    #1 req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (ce1 !== 1'b0 || sa1 !== 18'h9) begin bad++; $display("FAIL rm_in_hi got=ce%b %h exp=ce0 00009", ce1, sa1); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({ce1, we1, oe1, lb1, ub1} !== 5'h1F || ack1 !== 1'b0 || stall1 !== 1'b0) begin bad++;
      $display("FAIL rm_after got=%b ack%b st%b exp=11111 ack0 st0", {ce1, we1, oe1, lb1, ub1}, ack1, stall1); end
    rst_n = 1'b1;
    exp_rd1 = 32'h0;
    nack = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ack1 === 1'b1) nack++;
    end
    total++; if (nack !== 0) begin bad++; $display("FAIL rm_no_ack got=%0d exp=0", nack); end
    txn(1'b0, 1'b1, 19'h00010, 4'hF, 32'hDEADBEEF, 1'b0, lat);
    ref_store(1'b0, 4, 4'hF, 32'hDEADBEEF);
    total++; if (lat !== 3 || snap_addr[1] !== 18'h8 || snap_addr[2] !== 18'h9) begin bad++;
      $display("FAIL rm_restore got=lat%0d %h %h exp=lat3 8 9", lat, snap_addr[1], snap_addr[2]); end
    total++; if (got_rd !== 32'h0) begin bad++; $display("FAIL rm_rdata got=%h exp=0", got_rd); end
    txn(1'b0, 1'b0, 19'h00010, 4'h0, 32'h0, 1'b0, lat);
    total++; if (got_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rm_reload got=%h exp=deadbeef", got_rd); end
  endtask

  initial begin
    test_reset();
    test_store_basic();
    test_load_basic();
    test_partial_store();
    test_empty_store();
    test_boundary();
    test_wait3();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
